// File: rtl/fractal_sync_credit_sched.sv
// Credit-gated round-robin scheduler: pops one non-empty input queue per cycle
// while downstream credits remain and forwards the popped element one cycle later.
module fractal_sync_credit_sched #(
    parameter int unsigned IN_PORTS  = 1,
    parameter int unsigned CREDITS   = 4,
    parameter type         arbiter_t = logic
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    output logic                             pop_o     [IN_PORTS],
    input  logic                             empty_i   [IN_PORTS],
    input  arbiter_t                         element_i [IN_PORTS],
    output logic                             valid_o,
    output arbiter_t                         element_o,
    input  logic                             credit_i,
    output logic [$clog2(CREDITS+1)-1:0]     credit_cnt_o,
    output logic                             overflow_o
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned PW = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;

    generate
        if (IN_PORTS == 0) begin : g_bad_ports
            $fatal(1, "fractal_sync_credit_sched: IN_PORTS must be at least 1");
        end
        if (CREDITS == 0) begin : g_bad_credits
            $fatal(1, "fractal_sync_credit_sched: CREDITS must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [PW-1:0] rr_q;
    logic          valid_q;
    arbiter_t      element_q;
    logic          overflow_q;

    logic          found_hi;
    logic          found_lo;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    arbiter_t      hi_elem;
    arbiter_t      lo_elem;
    logic [PW-1:0] grant_idx;
    arbiter_t      grant_elem;
    logic          any_req;
    logic          send;

    // Wrap-around scan split in two: first requester at or above rr_q wins,
    // otherwise the lowest requester overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_elem  = '0;
        lo_elem  = '0;
        for (int unsigned i = 0; i < IN_PORTS; i++) begin
            if (!empty_i[i]) begin
                if (!found_hi && (i >= 32'(rr_q))) begin
                    found_hi = 1'b1;
                    hi_idx   = PW'(i);
                    hi_elem  = element_i[i];
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = PW'(i);
                    lo_elem  = element_i[i];
                end
            end
        end
    end

    always_comb begin
        any_req    = found_lo;
        grant_idx  = found_hi ? hi_idx : lo_idx;
        grant_elem = found_hi ? hi_elem : lo_elem;
        send       = rst_ni && any_req && (cnt_q != '0);
    end

    always_comb begin
        for (int unsigned i = 0; i < IN_PORTS; i++) begin
            pop_o[i] = send && (grant_idx == PW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= CW'(CREDITS);
            rr_q       <= '0;
            valid_q    <= 1'b0;
            element_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q   <= send;
            element_q <= send ? grant_elem : '0;

            if (send) begin
                rr_q <= (grant_idx == PW'(IN_PORTS - 1)) ? '0 : grant_idx + PW'(1);
            end

            // A credit arriving at full count is only an overflow when no send
            // consumes a slot in the same cycle.
            case ({send, credit_i})
                2'b10:   cnt_q <= cnt_q - CW'(1);
                2'b01: begin
                    if (cnt_q == CW'(CREDITS)) begin
                        overflow_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid_o      = valid_q;
    assign element_o    = element_q;
    assign credit_cnt_o = cnt_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fractal_sync_credit_sched.sv
// Directed self-checking bench for fractal_sync_credit_sched (4 ports, 2 credits, 8-bit elements).
module tb_fractal_sync_credit_sched;

    typedef logic [7:0] elem_t;

    logic       clk;
    logic       rst_n;
    logic       pop   [4];
    logic       empty [4];
    elem_t      elem  [4];
    logic       valid;
    elem_t      elem_out;
    logic       credit;
    logic [1:0] cnt;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    fractal_sync_credit_sched #(
        .IN_PORTS (4),
        .CREDITS  (2),
        .arbiter_t(elem_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pop_o       (pop),
        .empty_i     (empty),
        .element_i   (elem),
        .valid_o     (valid),
        .element_o   (elem_out),
        .credit_i    (credit),
        .credit_cnt_o(cnt),
        .overflow_o  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pops();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = pop[i];
        return v;
    endfunction

    task automatic set_empty(input logic [3:0] m);
        for (int i = 0; i < 4; i++) empty[i] = m[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_empty(4'b0000);
        credit = 1'b0;
        rst_n  = 1'b0;
        tick();
        #1;
        checks++;
        if (pops() !== 4'b0000) begin
            errors++; $display("FAIL reset_pop_in_reset: got %b want 0000", pops());
        end
        set_empty(4'b1111);
        rst_n = 1'b1;
        tick();
        checks++;
        if (cnt !== 2'd2) begin
            errors++; $display("FAIL reset_cnt: got %0d want 2", cnt);
        end
        checks++;
        if (valid !== 1'b0 || elem_out !== 8'h00) begin
            errors++; $display("FAIL reset_valid: got %b/%h want 0/00", valid, elem_out);
        end
        checks++;
        if (pops() !== 4'b0000) begin
            errors++; $display("FAIL reset_pop: got %b want 0000", pops());
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_fairness();
        int g;
        do_reset();
        set_empty(4'b0000);
        credit = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            checks++;
            if (pops() !== (4'b0001 << g)) begin
                errors++; $display("FAIL fair_pop[%0d]: got %b want %b", k, pops(), 4'b0001 << g);
            end
            tick();
            checks++;
            if (valid !== 1'b1 || elem_out !== elem_t'(8'hA0 + g)) begin
                errors++; $display("FAIL fair_out[%0d]: got %b/%h want 1/%h", k, valid, elem_out, 8'hA0 + g);
            end
            checks++;
            if (cnt !== 2'd2) begin
                errors++; $display("FAIL fair_cnt[%0d]: got %0d want 2", k, cnt);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL fair_no_overflow: got %b want 0", overflow);
        end
        credit = 1'b0;
    endtask

    task automatic test_exhaustion();
        logic [3:0] exp_pop [7];
        logic [1:0] exp_cnt [7];
        exp_pop = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        exp_cnt = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        do_reset();
        set_empty(4'b0000);
        for (int c = 0; c < 7; c++) begin
            credit = (c == 5);
            #1;
            checks++;
            if (pops() !== exp_pop[c]) begin
                errors++; $display("FAIL exh_pop[%0d]: got %b want %b", c, pops(), exp_pop[c]);
            end
            tick();
            checks++;
            if (cnt !== exp_cnt[c]) begin
                errors++; $display("FAIL exh_cnt[%0d]: got %0d want %0d", c, cnt, exp_cnt[c]);
            end
            checks++;
            if (exp_pop[c] == 4'b0000) begin
                if (valid !== 1'b0 || elem_out !== 8'h00) begin
                    errors++; $display("FAIL exh_idle_out[%0d]: got %b/%h want 0/00", c, valid, elem_out);
                end
            end else if (valid !== 1'b1 || elem_out !== elem_t'(8'hA0 + c)) begin
                // pops happen at ports 0,1,2 in cycles 0,1,6 -> elements A0,A1,A2
                if (!(c == 6 && valid === 1'b1 && elem_out === 8'hA2)) begin
                    errors++; $display("FAIL exh_out[%0d]: got %b/%h", c, valid, elem_out);
                end
            end
        end
        credit = 1'b0;
    endtask

    task automatic test_wrap_skip();
        do_reset();
        credit = 1'b1;
        set_empty(4'b1101);
        #1;
        checks++;
        if (pops() !== 4'b0010) begin
            errors++; $display("FAIL wrap_first: got %b want 0010", pops());
        end
        tick();
        set_empty(4'b0110);
        #1;
        checks++;
        if (pops() !== 4'b1000) begin
            errors++; $display("FAIL wrap_skip3: got %b want 1000", pops());
        end
        tick();
        checks++;
        if (valid !== 1'b1 || elem_out !== 8'hA3) begin
            errors++; $display("FAIL wrap_out3: got %b/%h want 1/a3", valid, elem_out);
        end
        #1;
        checks++;
        if (pops() !== 4'b0001) begin
            errors++; $display("FAIL wrap_to0: got %b want 0001", pops());
        end
        tick();
        checks++;
        if (valid !== 1'b1 || elem_out !== 8'hA0) begin
            errors++; $display("FAIL wrap_out0: got %b/%h want 1/a0", valid, elem_out);
        end
        credit = 1'b0;
        set_empty(4'b1111);
        #1;
        checks++;
        if (pops() !== 4'b0000) begin
            errors++; $display("FAIL idle_pop: got %b want 0000", pops());
        end
        tick();
        checks++;
        if (valid !== 1'b0 || cnt !== 2'd2) begin
            errors++; $display("FAIL idle_state: got valid=%b cnt=%0d want 0/2", valid, cnt);
        end
        set_empty(4'b0000);
        #1;
        checks++;
        if (pops() !== 4'b0010) begin
            errors++; $display("FAIL idle_rr_held: got %b want 0010", pops());
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        set_empty(4'b1111);
        credit = 1'b1;
        tick();
        credit = 1'b0;
        checks++;
        if (cnt !== 2'd2 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got cnt=%0d ovf=%b want 2/1", cnt, overflow);
        end
        set_empty(4'b0000);
        tick();
        tick();
        tick();
        checks++;
        if (overflow !== 1'b1 || cnt !== 2'd0) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b cnt=%0d want 1/0", overflow, cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        set_empty(4'b0000);
        credit = 1'b1;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || elem_out !== 8'hA1) begin
            errors++; $display("FAIL mid_pre: got %b/%h want 1/a1", valid, elem_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || elem_out !== 8'h00) begin
            errors++; $display("FAIL mid_valid: got %b/%h want 0/00", valid, elem_out);
        end
        checks++;
        if (pops() !== 4'b0000) begin
            errors++; $display("FAIL mid_pop_in_reset: got %b want 0000", pops());
        end
        credit = 1'b0;
        tick();
        rst_n = 1'b1;
        set_empty(4'b1000);
        #1;
        checks++;
        if (cnt !== 2'd2) begin
            errors++; $display("FAIL mid_cnt: got %0d want 2", cnt);
        end
        set_empty(4'b0001);
        #1;
        checks++;
        if (pops() !== 4'b0010) begin
            errors++; $display("FAIL mid_rr0: got %b want 0010", pops());
        end
        tick();
        checks++;
        if (valid !== 1'b1 || elem_out !== 8'hA1 || cnt !== 2'd1) begin
            errors++; $display("FAIL mid_after: got %b/%h cnt=%0d want 1/a1/1", valid, elem_out, cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) elem[i] = elem_t'(8'hA0 + i);
        rst_n  = 1'b0;
        credit = 1'b0;
        set_empty(4'b1111);
        test_reset();
        test_fairness();
        test_exhaustion();
        test_wrap_skip();
        test_overflow();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
